// File: rtl/ahb_params_pkg.sv
// Shared bus parameters for the AHB-side memory subsystem.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ahb_params_pkg;
   localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for a single-port 2048x32 SRAM with round-robin ties and burst lock.
// Latency: command issued combinationally in the grant cycle; read data valid one cycle later.
// Backpressure: a requester holds req until gnt; a locked owner can deny the other for up to MAX_BURST beats.
//
// Ports:
//   HCLK, HRESET            clock, asynchronous active-high reset
//   req, lock, we [1:0]     per-requester request, burst lock, write(1)/read(0)
//   addrN, beN, wdataN      per-requester command fields (N = 0, 1)
//   gnt [1:0]               combinational grant (one-hot or zero)
//   rvalid [1:0], rdataN    read return, rdataN is zero while rvalid[N] is low
//   mem_*                   SRAM command from the granted requester, zero when idle
//   mem_rdata               SRAM read data, one cycle after a read command
//   conflict_cnt            saturating contention counter, present only when
//                           SRAM_ARB_CONFLICT_CNT_EN is defined; tied to zero otherwise
module sram_port_arbiter
   import ahb_params_pkg::*;
#(
   parameter int ADDR_WIDTH = 11,
   parameter int MAX_BURST  = 8
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic [1:0]                req,
   input  logic [1:0]                lock,
   input  logic [1:0]                we,
   input  logic [ADDR_WIDTH-1:0]     addr0,
   input  logic [ADDR_WIDTH-1:0]     addr1,
   input  logic [DATA_WIDTH/8-1:0]   be0,
   input  logic [DATA_WIDTH/8-1:0]   be1,
   input  logic [DATA_WIDTH-1:0]     wdata0,
   input  logic [DATA_WIDTH-1:0]     wdata1,
   output logic [1:0]                gnt,
   output logic [1:0]                rvalid,
   output logic [DATA_WIDTH-1:0]     rdata0,
   output logic [DATA_WIDTH-1:0]     rdata1,
   output logic                      mem_cs,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH/8-1:0]   mem_be,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   output logic [15:0]               conflict_cnt
);

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t     state;
   logic       last_gnt;     // requester that took the most recent beat
   logic [3:0] beat_cnt;     // beats already taken in the current locked burst
   logic [1:0] rd_pend;      // read accepted last cycle, per requester
   logic       gidx;         // index of the granted requester (valid when |gnt)
   logic       in_burst;     // this beat continues the current owner's burst
   logic [4:0] burst_len;    // burst length including this beat

   // Grant: a lock owner that still requests wins outright; otherwise plain
   // arbitration with ties going to the requester that did not go last.
   // A released lock falls through to this same path in the same cycle.
   always_comb begin
      gnt = 2'b00;
      if (!HRESET) begin
         if (state == LOCK0 && req[0])
            gnt = 2'b01;
         else if (state == LOCK1 && req[1])
            gnt = 2'b10;
         else if (req == 2'b11)
            gnt = last_gnt ? 2'b01 : 2'b10;
         else
            gnt = req;
      end
   end

   assign gidx      = gnt[1];
   assign in_burst  = (state == LOCK0 && gnt[0]) || (state == LOCK1 && gnt[1]);
   assign burst_len = in_burst ? {1'b0, beat_cnt} + 5'd1 : 5'd1;

   // SRAM command: gnt already implies req, so any grant is an accepted beat.
   assign mem_cs    = |gnt;
   assign mem_we    = mem_cs ? we[gidx] : 1'b0;
   assign mem_addr  = !mem_cs ? '0 : (gidx ? addr1  : addr0);
   assign mem_be    = !mem_cs ? '0 : (gidx ? be1    : be0);
   assign mem_wdata = !mem_cs ? '0 : (gidx ? wdata1 : wdata0);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state    <= IDLE;
         last_gnt <= 1'b1;       // requester 0 wins the first tie
         beat_cnt <= 4'd0;
         rd_pend  <= 2'b00;
      end else begin
         rd_pend <= gnt & ~we;
         if (mem_cs) begin
            last_gnt <= gidx;
            // Reaching MAX_BURST drops the lock so the other side wins the next tie.
            if (lock[gidx] && (burst_len < 5'(MAX_BURST))) begin
               state    <= gidx ? LOCK1 : LOCK0;
               beat_cnt <= burst_len[3:0];
            end else begin
               state    <= IDLE;
               beat_cnt <= 4'd0;
            end
         end else begin
            state    <= IDLE;
            beat_cnt <= 4'd0;
         end
      end
   end

   assign rvalid = rd_pend;
   assign rdata0 = rd_pend[0] ? mem_rdata : '0;
   assign rdata1 = rd_pend[1] ? mem_rdata : '0;

`ifdef SRAM_ARB_CONFLICT_CNT_EN
   logic [15:0] conflict_q;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)
         conflict_q <= 16'h0000;
      else if (req == 2'b11 && mem_cs && conflict_q != 16'hFFFF)
         conflict_q <= conflict_q + 16'd1;
   end

   assign conflict_cnt = conflict_q;
`else
   assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against a behavioural model.
// Latency: model predicts grant/command in-cycle and read return one cycle later.
// Backpressure: requests are held/changed freely each cycle; the model tracks lock ownership.
module tb_sram_port_arbiter;
   localparam int AW = 11;
   localparam int MB = 8;
`ifdef SRAM_ARB_CONFLICT_CNT_EN
   localparam int EXP_CONF10 = 10;
`else
   localparam int EXP_CONF10 = 0;
`endif

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic [1:0]    req, lock, we;
   logic [AW-1:0] addr0, addr1;
   logic [3:0]    be0, be1;
   logic [31:0]   wdata0, wdata1;
   logic [1:0]    gnt, rvalid;
   logic [31:0]   rdata0, rdata1;
   logic          mem_cs, mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic [15:0]   conflict_cnt;

   sram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .req(req), .lock(lock), .we(we),
      .addr0(addr0), .addr1(addr1), .be0(be0), .be1(be1),
      .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .rvalid(rvalid),
      .rdata0(rdata0), .rdata1(rdata1), .mem_cs(mem_cs), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
   );

   always #5 HCLK = ~HCLK;

   // SRAM behavioural model driven by the DUT command.
   logic [31:0] sram [0:2047];
   always @(posedge HCLK) begin
      if (mem_cs) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: who owns the bus, how long they have held it, who went last.
   int          m_owner, m_run, m_last, m_conf;
   logic [1:0]  m_rv;
   logic [31:0] m_rd0, m_rd1;
   logic [31:0] ref_mem [0:2047];
   logic [1:0]  obs_gnt;

   task automatic model_reset();
      m_owner = -1; m_run = 0; m_last = 1; m_conf = 0;
      m_rv = 2'b00; m_rd0 = 0; m_rd1 = 0;
   endtask

   // One clock: entered just after a falling edge with inputs driven, returns at the next falling edge.
   task automatic cycle();
      int          g, nrun;
      logic        ew;
      logic [31:0] ea, ed, eb;
      #1;
      g = -1;
      if (m_owner >= 0 && req[m_owner]) g = m_owner;
      else if (req == 2'b11)            g = 1 - m_last;
      else if (req == 2'b01)            g = 0;
      else if (req == 2'b10)            g = 1;
      obs_gnt = gnt;
      ew = 0; ea = 0; ed = 0; eb = 0;
      if (g == 0) begin ew = we[0]; ea = 32'(addr0); ed = wdata0; eb = 32'(be0); end
      if (g == 1) begin ew = we[1]; ea = 32'(addr1); ed = wdata1; eb = 32'(be1); end
      chk("gnt",       32'(gnt),    (g < 0) ? 32'd0 : 32'(1 << g));
      chk("mem_cs",    32'(mem_cs), 32'(g >= 0));
      chk("mem_we",    32'(mem_we), 32'(ew));
      chk("mem_addr",  32'(mem_addr), ea);
      chk("mem_be",    32'(mem_be), eb);
      chk("mem_wdata", mem_wdata,   ed);
      chk("rvalid",    32'(rvalid), 32'(m_rv));
      chk("rdata0",    rdata0, m_rv[0] ? m_rd0 : 32'd0);
      chk("rdata1",    rdata1, m_rv[1] ? m_rd1 : 32'd0);
      chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
`ifdef SRAM_ARB_CONFLICT_CNT_EN
      if (req == 2'b11 && g >= 0 && m_conf < 65535) m_conf++;
`endif
      m_rv = 2'b00;
      if (g >= 0) begin
         if (!ew) begin
            m_rv[g] = 1'b1;
            if (g == 0) m_rd0 = ref_mem[addr0]; else m_rd1 = ref_mem[addr1];
         end else begin
            for (int b = 0; b < 4; b++)
               if (eb[b]) ref_mem[ea[AW-1:0]][8*b +: 8] = ed[8*b +: 8];
         end
         nrun   = (m_owner == g) ? m_run + 1 : 1;
         m_last = g;
         if (lock[g] && nrun < MB) begin m_owner = g;  m_run = nrun; end
         else                      begin m_owner = -1; m_run = 0;    end
      end else begin
         m_owner = -1; m_run = 0;
      end
      @(negedge HCLK);
   endtask

   logic [1:0] seq [0:11];
   int         nburst;

   initial begin
      for (int i = 0; i < 2048; i++) begin sram[i] = 0; ref_mem[i] = 0; end
      mem_rdata = 0;
      model_reset();
      HRESET = 1'b1;
      req = 2'b11; lock = 2'b00; we = 2'b00;
      addr0 = 11'h010; addr1 = 11'h020;
      be0 = 4'hF; be1 = 4'hF; wdata0 = 0; wdata1 = 0;

      // Reset state
      #2;
      chk("rst_gnt",    32'(gnt),    32'd0);
      chk("rst_mem_cs", 32'(mem_cs), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_conf",   32'(conflict_cnt), 32'd0);
      @(negedge HCLK); @(negedge HCLK);
      HRESET = 1'b0;

      // Two readers contending: strict alternation starting with requester 0
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("rr_alt", 32'(obs_gnt), (i % 2 == 1) ? 32'd2 : 32'd1);
      end
      #1 chk("conflict10", 32'(conflict_cnt), 32'(EXP_CONF10));

      // Write then read back through requester 0
      req = 2'b01; we = 2'b01; addr0 = 11'h005; wdata0 = 32'hDEADBEEF; be0 = 4'hF;
      cycle();
      we = 2'b00;
      cycle();
      req = 2'b00;
      #1 chk("rd_after_wr", rdata0, 32'hDEADBEEF);
      chk("rd_after_wr_vld", 32'(rvalid), 32'd1);
      cycle();

      // Locked burst from requester 1 is cut at MAX_BURST
      req = 2'b01; lock = 2'b00;
      cycle();
      req = 2'b11; lock = 2'b10;
      for (int i = 0; i < 12; i++) begin
         cycle();
         seq[i] = obs_gnt;
      end
      nburst = 0;
      while (nburst < 12 && seq[nburst] == 2'b10) nburst++;
      chk("burst_len", 32'(nburst), 32'(MB));
      chk("burst_yield", 32'(seq[MB]), 32'd1);

      // Requester 0 locked, drops mid-burst: requester 1 gets the same cycle
      req = 2'b01; lock = 2'b01;
      cycle(); cycle(); cycle();
      req = 2'b10;
      cycle();
      chk("lock_drop", 32'(obs_gnt), 32'd2);
      req = 2'b11; lock = 2'b00;
      cycle();
      chk("idle_after_drop", 32'(obs_gnt), 32'd1);

      // Reset right after a read grant kills the return
      req = 2'b01; we = 2'b00; addr0 = 11'h005;
      #1 chk("pre_rst_gnt", 32'(gnt), 32'd1);
      @(posedge HCLK);
      #1 HRESET = 1'b1;
      req = 2'b11;
      #1;
      chk("rst_kill_rvalid", 32'(rvalid), 32'd0);
      chk("rst_kill_gnt",    32'(gnt),    32'd0);
      chk("rst_kill_cs",     32'(mem_cs), 32'd0);
      chk("rst_kill_rdata0", rdata0,      32'd0);
      @(negedge HCLK); @(negedge HCLK);
      chk("rst_hold_rvalid", 32'(rvalid), 32'd0);
      HRESET = 1'b0;
      model_reset();
      cycle();
      chk("first_tie", 32'(obs_gnt), 32'd1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         req    = 2'($urandom);
         lock   = 2'($urandom);
         we     = 2'($urandom);
         addr0  = AW'($urandom_range(31));
         addr1  = AW'($urandom_range(31));
         be0    = 4'($urandom);
         be1    = 4'($urandom);
         wdata0 = $urandom;
         wdata1 = $urandom;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
